// File: rtl/menu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// menu_defs : shared constants, state encoding and value tables for menu_ctrl
// Rev 1.0
// ============================================================================
package menu_defs;

   // Scan codes; bit 8 flags the E0 extended prefix
   localparam logic [8:0] KEY_UP    = 9'h175;
   localparam logic [8:0] KEY_DOWN  = 9'h172;
   localparam logic [8:0] KEY_LEFT  = 9'h16B;
   localparam logic [8:0] KEY_RIGHT = 9'h174;
   localparam logic [8:0] KEY_ENTER = 9'h05A;

   localparam int unsigned MAX_ROUNDS = 63;

   localparam int KEY_W = 9;
   localparam int RES_W = 10;
   localparam int SUM_W = 16;
   localparam int CNT_W = 6;
   localparam int VAL_W = 7;
   localparam int IDX_W = 2;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PLAYING = 2'd1,
      ST_UPDATE  = 2'd2,
      ST_DIVIDE  = 2'd3
   } state_t;

   // Time mode offers 15/30/60 seconds, word mode 10/25/50 words
   function automatic logic [VAL_W-1:0] menu_value(input logic mode,
                                                   input logic [IDX_W-1:0] idx);
      logic [VAL_W-1:0] v;
      case ({mode, idx})
         3'b000:  v = 7'd15;
         3'b001:  v = 7'd30;
         3'b010:  v = 7'd60;
         3'b100:  v = 7'd10;
         3'b101:  v = 7'd25;
         3'b110:  v = 7'd50;
         default: v = 7'd15;
      endcase
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/menu_ctrl_if.sv
`default_nettype none
// ============================================================================
// menu_ctrl_if : key/round inputs and menu/statistics outputs of menu_ctrl
// Rev 1.0
// ============================================================================
interface menu_ctrl_if;
   import menu_defs::*;

   logic             key_valid;
   logic [KEY_W-1:0] key_code;
   logic             round_done;
   logic             round_abort;
   logic [RES_W-1:0] round_wpm;
   logic [RES_W-1:0] round_acc;

   logic             mode;
   logic [VAL_W-1:0] value;
   logic             start;
   logic             busy;
   logic [RES_W-1:0] wpm_best;
   logic [RES_W-1:0] acc_best;
   logic [RES_W-1:0] wpm_average;
   logic [RES_W-1:0] acc_average;

   modport master (
      output key_valid, key_code, round_done, round_abort, round_wpm, round_acc,
      input  mode, value, start, busy, wpm_best, acc_best, wpm_average, acc_average
   );

   modport slave (
      input  key_valid, key_code, round_done, round_abort, round_wpm, round_acc,
      output mode, value, start, busy, wpm_best, acc_best, wpm_average, acc_average
   );

endinterface
`default_nettype wire

// File: rtl/menu_ctrl_seq_div.sv
`default_nettype none
// ============================================================================
// seq_div : restoring divider, one quotient bit per cycle, W cycles per divide
// Rev 1.0
// ============================================================================
module seq_div #(
   parameter int W     = 16,
   parameter int OUT_W = 10
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             start,
   input  wire logic [W-1:0]     dividend,
   input  wire logic [W-1:0]     divisor,
   output logic                  done,
   output logic [OUT_W-1:0]      quotient
);

   localparam int CW = $clog2(W) + 1;

   logic [CW-1:0] r_left;
   logic [W-1:0]  r_rem;
   logic [W-1:0]  r_quo;
   logic [W-1:0]  r_dsr;

   logic [W-1:0]  w_rem_in;
   logic [W-1:0]  w_quo_in;
   logic [W-1:0]  w_dsr;
   logic [W:0]    w_shift;
   logic          w_ge;
   logic [W-1:0]  w_rem_nxt;
   logic [W-1:0]  w_quo_nxt;

   // The start cycle already performs the first step on the fresh operands,
   // so a division occupies exactly W clock edges.
   always_comb begin
      w_rem_in  = start ? '0 : r_rem;
      w_quo_in  = start ? dividend : r_quo;
      w_dsr     = start ? divisor : r_dsr;
      w_shift   = {w_rem_in, w_quo_in[W-1]};
      w_ge      = (w_shift >= {1'b0, w_dsr});
      w_rem_nxt = w_ge ? W'(w_shift - {1'b0, w_dsr}) : W'(w_shift);
      w_quo_nxt = {w_quo_in[W-2:0], w_ge};
   end

   // done marks the cycle whose edge retires the last bit; quotient is valid then
   assign done     = (r_left == CW'(1)) && !start;
   assign quotient = w_quo_nxt[OUT_W-1:0];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_left <= '0;
         r_rem  <= '0;
         r_quo  <= '0;
         r_dsr  <= '0;
      end else if (start) begin
         r_left <= CW'(W - 1);
         r_rem  <= w_rem_nxt;
         r_quo  <= w_quo_nxt;
         r_dsr  <= divisor;
      end else if (r_left != '0) begin
         r_left <= r_left - CW'(1);
         r_rem  <= w_rem_nxt;
         r_quo  <= w_quo_nxt;
      end
   end

endmodule
`default_nettype wire

// File: rtl/menu_ctrl.sv
`default_nettype none
// ============================================================================
// menu_ctrl : menu key decoder, round start pulse and WPM/accuracy statistics
// Rev 1.0
// ============================================================================
module menu_ctrl
   import menu_defs::*;
(
   input  wire logic   clk,
   input  wire logic   rst,
   menu_ctrl_if.slave  bus
);

   localparam logic [CNT_W-1:0] c_max_rounds = CNT_W'(MAX_ROUNDS);
   localparam int               c_div_w      = SUM_W;

   state_t           r_state;
   state_t           w_state_nxt;

   logic             r_mode;
   logic [IDX_W-1:0] r_idx;
   logic             r_start;
   logic [RES_W-1:0] r_lat_wpm;
   logic [RES_W-1:0] r_lat_acc;
   logic [RES_W-1:0] r_wpm_best;
   logic [RES_W-1:0] r_acc_best;
   logic [RES_W-1:0] r_wpm_avg;
   logic [RES_W-1:0] r_acc_avg;
   logic [RES_W-1:0] r_q_wpm;
   logic [SUM_W-1:0] r_sum_wpm;
   logic [SUM_W-1:0] r_sum_acc;
   logic [CNT_W-1:0] r_count;
   logic [4:0]       r_div_cnt;

   logic             w_enter;
   logic             w_busy;
   logic             w_div_start;
   logic             w_div_done;
   logic [RES_W-1:0] w_div_q;
   logic [SUM_W-1:0] w_div_dividend;
   logic [SUM_W-1:0] w_div_divisor;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_enter     = 1'b0;
      w_busy      = 1'b0;
      w_div_start = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (bus.key_valid && (bus.key_code == KEY_ENTER)) begin
               w_enter     = 1'b1;
               w_state_nxt = ST_PLAYING;
            end
         end
         ST_PLAYING: begin
            if (bus.round_abort)     w_state_nxt = ST_IDLE;
            else if (bus.round_done) w_state_nxt = ST_UPDATE;
         end
         ST_UPDATE: begin
            w_busy      = 1'b1;
            w_state_nxt = ST_DIVIDE;
         end
         ST_DIVIDE: begin
            w_busy      = 1'b1;
            // WPM division occupies slots 0..15, accuracy slots 16..31
            w_div_start = (r_div_cnt == 5'd0) || (r_div_cnt == 5'd16);
            if (w_div_done && r_div_cnt[4]) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_mode     <= 1'b0;
         r_idx      <= '0;
         r_start    <= 1'b0;
         r_lat_wpm  <= '0;
         r_lat_acc  <= '0;
         r_wpm_best <= '0;
         r_acc_best <= '0;
         r_wpm_avg  <= '0;
         r_acc_avg  <= '0;
         r_q_wpm    <= '0;
         r_sum_wpm  <= '0;
         r_sum_acc  <= '0;
         r_count    <= '0;
         r_div_cnt  <= '0;
      end else begin
         r_start <= w_enter;
         case (r_state)
            ST_IDLE: begin
               if (bus.key_valid) begin
                  case (bus.key_code)
                     KEY_UP:   r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
                     KEY_DOWN: r_idx <= (r_idx == 2'd0) ? 2'd2 : r_idx - 2'd1;
                     KEY_LEFT, KEY_RIGHT: begin
                        r_mode <= ~r_mode;
                        r_idx  <= '0;
                     end
                     default: ;
                  endcase
               end
            end
            ST_PLAYING: begin
               if (bus.round_done && !bus.round_abort) begin
                  r_lat_wpm <= bus.round_wpm;
                  r_lat_acc <= bus.round_acc;
               end
            end
            ST_UPDATE: begin
               if (r_lat_wpm > r_wpm_best) r_wpm_best <= r_lat_wpm;
               if (r_lat_acc > r_acc_best) r_acc_best <= r_lat_acc;
               // Saturated history keeps averaging over the first MAX_ROUNDS rounds
               if (r_count < c_max_rounds) begin
                  r_sum_wpm <= r_sum_wpm + SUM_W'(r_lat_wpm);
                  r_sum_acc <= r_sum_acc + SUM_W'(r_lat_acc);
                  r_count   <= r_count + CNT_W'(1);
               end
               r_div_cnt <= '0;
            end
            ST_DIVIDE: begin
               r_div_cnt <= r_div_cnt + 5'd1;
               if (w_div_done && !r_div_cnt[4]) r_q_wpm <= w_div_q;
               if (w_div_done && r_div_cnt[4]) begin
                  r_wpm_avg <= r_q_wpm;
                  r_acc_avg <= w_div_q;
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------- divider
   assign w_div_dividend = r_div_cnt[4] ? r_sum_acc : r_sum_wpm;
   assign w_div_divisor  = SUM_W'(r_count);

   seq_div #(
      .W     (c_div_w),
      .OUT_W (RES_W)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (w_div_start),
      .dividend (w_div_dividend),
      .divisor  (w_div_divisor),
      .done     (w_div_done),
      .quotient (w_div_q)
   );

   // ---------------------------------------------------------------- outputs
   assign bus.mode        = r_mode;
   assign bus.value       = menu_value(r_mode, r_idx);
   assign bus.start       = r_start;
   assign bus.busy        = w_busy;
   assign bus.wpm_best    = r_wpm_best;
   assign bus.acc_best    = r_acc_best;
   assign bus.wpm_average = r_wpm_avg;
   assign bus.acc_average = r_acc_avg;

endmodule
`default_nettype wire

// File: doc/menu_ctrl.md
Name: menu_ctrl

Overview:
Input-side counterpart of the menu screen renderer. It decodes keyboard events into the menu selection (mode, value) and issues a one-cycle start pulse to the game core. It also accepts finished-round results and maintains best and running-average WPM/accuracy. Its outputs drive the menu renderer's mode, value, wpm_best, wpm_average, acc_best and acc_average inputs directly.

Parameters:
KEY_UP, 9'h175, scan code (bit8 = E0 extended) for next value
KEY_DOWN, 9'h172, scan code for previous value
KEY_LEFT, 9'h16B, scan code for toggling mode
KEY_RIGHT, 9'h174, scan code for toggling mode
KEY_ENTER, 9'h05A, scan code for starting a round
MAX_ROUNDS, 63, saturation limit of the round counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
key_valid  in  1  one-cycle strobe; key_code is valid
key_code  in  9  make code; bit8 = extended
round_done  in  1  one-cycle strobe; round finished, results valid
round_abort  in  1  one-cycle strobe; round abandoned
round_wpm  in  10  WPM of the finished round
round_acc  in  10  accuracy of the finished round, 0..100
mode  out  1  0 = time, 1 = word
value  out  7  selected limit (seconds or words)
start  out  1  one-cycle pulse that starts a round
busy  out  1  high while statistics are being updated
wpm_best, acc_best  out  10 each  best values so far
wpm_average, acc_average  out  10 each  floor of the running averages

Behaviour:
- Reset values:
  - mode=0, option index=0, so value=15.
  - start=0, busy=0.
  - All best, average, sum and count registers are 0.
  - State is IDLE.
- Value table (combinational from mode and index 0..2):
  - time mode: 15, 30, 60
  - word mode: 10, 25, 50
- States: IDLE, PLAYING, UPDATE, DIVIDE.
- IDLE: a key is acted on only when key_valid=1.
  - KEY_UP: index+1, wrapping 2→0.
  - KEY_DOWN: index−1, wrapping 0→2.
  - KEY_LEFT or KEY_RIGHT: toggle mode and reset index to 0.
  - KEY_ENTER: start=1 for exactly one cycle, then go to PLAYING.
  - Any other code is ignored.
  - round_done and round_abort are ignored.
- PLAYING:
  - All keys are ignored. mode and value stay frozen.
  - round_abort=1 → IDLE, statistics untouched. Abort wins if it arrives in the same cycle as round_done.
  - round_done=1 → latch round_wpm and round_acc, go to UPDATE.
- UPDATE (exactly 1 cycle, busy=1):
  - wpm_best = max(wpm_best, latched wpm); acc_best likewise for accuracy.
  - If count < MAX_ROUNDS: sum_wpm += wpm, sum_acc += acc (16-bit sums each), count += 1.
  - At MAX_ROUNDS, sums and count are frozen but bests still update.
  - Then go to DIVIDE.
- DIVIDE (busy=1):
  - Compute sum_wpm/count, then sum_acc/count, sequentially on one shared divider, 16 cycles each (32 total).
  - count is never 0 in this state.
  - Both averages are registered together on the last cycle, with the lower 10 bits of each quotient. Averages never show a half-updated pair.
  - Then go to IDLE.
- Latency, counting the round_done sample edge as cycle 0:
  - bests change at cycle 2;
  - averages change and busy falls at cycle 34.
- Keys arriving during UPDATE or DIVIDE are dropped; there is no queue.
- rst asserted mid-operation: immediate return to the reset values, and the divider is cleared.

Decomposition:
- Shared package (or include) menu_defs:
  - key code constants;
  - state encoding;
  - the time and word value tables;
  - stat widths (10-bit results, 16-bit sums, 6-bit count).
- One sub-module, seq_div: 16-bit by 16-bit restoring divider.
  - Interface: start/done handshake, 16 cycles per division, quotient output.
  - Instantiated once and reused for both averages.

Test Plan:
- Reset, then KEY_UP ×4 → value 15→30→60→15→30; then KEY_RIGHT → mode=1, value=10; then KEY_DOWN → value=50.
- KEY_ENTER in IDLE → start high for exactly 1 cycle; afterwards KEY_UP is ignored and value is unchanged.
- Round 1, wpm=40 acc=90:
  - best 40/90 at cycle 2;
  - average 40/90 and busy=0 at cycle 34.
- Round 2, wpm=61 acc=95:
  - best 61/95;
  - average wpm=50 (101/2), acc=92 (185/2).
- Round_done and round_abort in the same cycle while PLAYING → IDLE, all statistics unchanged, busy never asserts.
- Assert rst during DIVIDE (cycle 20) → all outputs at reset values next cycle; a subsequent 40/90 round gives average 40/90.
